apb3_arbiter: RTL
=================

// Module: apb3_arbiter
// PURPOSE
//  Two-requester APB3 arbiter and sequencer for a shared completer.
//  - Drives the `sel` input of the 2:1 APB3 bus mux.
//  - Generates completer PSEL/PENABLE itself, so every granted transfer gets a clean SETUP->ACCESS sequence.
//  - Gates PREADY/PSLVERR back to the granted requester only; the other requester is stalled in ACCESS.
//  - PADDR/PWRITE/PWDATA reach the completer through the mux; completer PSEL/PENABLE come from this block, not the mux.
// PARAMETERS
//  ROUND_ROBIN     1   1: round-robin between requesters; 0: fixed priority, requester 0 wins
//  TIMEOUT_CYCLES  16  max ACCESS cycles without m_pready before forced error completion; 0 disables
//  TO_W            $clog2(TIMEOUT_CYCLES+1)  timeout counter width (derived, do not override)
// PORTS
//  pclk        in   1  bus clock
//  presetn     in   1  asynchronous active-low reset
//  s0_psel     in   1  requester 0 PSEL
//  s1_psel     in   1  requester 1 PSEL
//  s0_pready   out  1  PREADY to requester 0
//  s0_pslverr  out  1  PSLVERR to requester 0
//  s1_pready   out  1  PREADY to requester 1
//  s1_pslverr  out  1  PSLVERR to requester 1
//  sel         out  1  mux select, 0 = requester 0, 1 = requester 1
//  m_psel      out  1  PSEL to completer
//  m_penable   out  1  PENABLE to completer
//  m_pready    in   1  completer PREADY
//  m_pslverr   in   1  completer PSLVERR
//  timeout_o   out  1  one-cycle flag: current transfer ended by timeout
// BEHAVIOUR
//  - One clock, `pclk`. Reset `presetn` is asynchronous and active-low.
//  - Reset values:
//    - state=IDLE, sel=0, last_grant=1 (requester 0 wins the first tie), timeout counter=0.
//    - All outputs 0 while presetn=0. Reset mid-transfer drops m_psel/m_penable immediately; no completion is reported.
//  - Requester PENABLE is ignored; the arbiter times the phases itself.
//  - FSM states IDLE, SETUP, ACCESS:
//    - IDLE: m_psel=0. If any s*_psel=1, pick a winner and register it into `sel` and last_grant, then go to SETUP next edge. Otherwise stay.
//    - SETUP: m_psel=1, m_penable=0. Always go to ACCESS next edge.
//    - ACCESS: m_psel=1, m_penable=1. On m_pready=1 or timeout_hit, go to IDLE next edge.
//  - Winner selection:
//    - Only one requesting: grant it.
//    - Both requesting, ROUND_ROBIN=1: grant !last_grant.
//    - Both requesting, ROUND_ROBIN=0: grant 0.
//  - `sel` is registered and changes only on the IDLE->SETUP edge, so it is stable for the whole transfer.
//  - Response path, combinational, valid only in ACCESS:
//    - sN_pready  = ACCESS & (sel==N) & (m_pready | timeout_hit)
//    - sN_pslverr = that same term & (m_pslverr | timeout_hit)
//    - The non-granted requester sees pready=0 and pslverr=0 at all times.
//  - m_psel = (SETUP|ACCESS) & psel of the granted requester.
//    - If the granted requester drops PSEL mid-transfer (protocol violation), m_psel and m_penable fall in the same cycle.
//    - The FSM then returns to IDLE next edge and reports no pready.
//  - Timeout:
//    - Counter clears on entering ACCESS and increments each ACCESS cycle with m_pready=0.
//    - timeout_hit = (TIMEOUT_CYCLES!=0) & ACCESS & ~m_pready & (cnt==TIMEOUT_CYCLES-1).
//    - timeout_o = timeout_hit. m_pready in the same cycle takes precedence, so no timeout is flagged.
//  - Latency:
//    - A PSEL first seen in cycle t gives SETUP at t+1 and ACCESS at t+2.
//    - Zero-wait completion is at t+2. The FSM is back in IDLE at t+3.
//    - Every transfer is followed by at least one IDLE cycle on the completer.
// TESTING
//  - Single s0 request, m_pready=1 in first ACCESS cycle -> sel=0, m_psel high t+1..t+2, m_penable high t+2 only, s0_pready=1 at t+2, s1_pready=0.
//  - s0 and s1 raise psel in the same cycle after reset, ROUND_ROBIN=1 -> grants 0,1,0,1 over four back-to-back transfers per requester; with ROUND_ROBIN=0 all s0 transfers finish first.
//  - Grant s1 with 3 wait states while s0 requests -> sel stays 1 throughout, s0_pready=0 throughout, s0 granted next; m_penable=0 in s0's SETUP cycle.
//  - TIMEOUT_CYCLES=16, m_pready held 0 -> at the 16th ACCESS cycle s0_pready=1, s0_pslverr=1, timeout_o=1 for one cycle; the FSM then returns to IDLE.
//  - m_pslverr=1 with m_pready=1 -> pslverr forwarded only to the granted requester; timeout_o=0.
//  - presetn low during ACCESS (async, mid-cycle) -> m_psel, m_penable, sN_pready drop immediately; after release the first tie grants requester 0.

Source files
------------

// File: rtl/apb3_arbiter.sv
// apb3_arbiter: two-requester APB3 arbiter and sequencer for one shared completer.
// Owns completer PSEL/PENABLE timing and routes PREADY/PSLVERR back to the granted requester only.
module apb3_arbiter #(
    parameter int  ROUND_ROBIN    = 1,
    parameter int  TIMEOUT_CYCLES = 16,
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic pclk,
    input  logic presetn,
    input  logic s0_psel,
    input  logic s1_psel,
    output logic s0_pready,
    output logic s0_pslverr,
    output logic s1_pready,
    output logic s1_pslverr,
    output logic sel,
    output logic m_psel,
    output logic m_penable,
    input  logic m_pready,
    input  logic m_pslverr,
    output logic timeout_o
);
    // A disabled timeout still needs a legal 1-bit counter.
    localparam int            CW       = (TO_W < 1) ? 1 : TO_W;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t        state, state_nxt;
    logic          sel_nxt;
    logic          last_grant, last_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          gpsel;
    logic          in_access;
    logic          timeout_hit;
    logic          done;
    logic          err;
    logic          winner;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state      <= IDLE;
            sel        <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            last_grant <= last_nxt;
            cnt        <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        last_nxt   = last_grant;
        cnt_nxt    = cnt;
        m_psel     = 1'b0;
        m_penable  = 1'b0;

        // A granted requester that drops PSEL aborts the transfer with no response.
        gpsel       = sel ? s1_psel : s0_psel;
        in_access   = (state == ACCESS) && gpsel;
        timeout_hit = (TIMEOUT_CYCLES != 0) && in_access && !m_pready && (cnt == CNT_LAST);
        done        = in_access && (m_pready || timeout_hit);
        err         = done && (m_pslverr || timeout_hit);

        if (s0_psel && s1_psel) begin
            winner = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
        end else begin
            winner = s1_psel;
        end

        case (state)
            IDLE: begin
                if (s0_psel || s1_psel) begin
                    state_nxt = SETUP;
                    sel_nxt   = winner;
                    last_nxt  = winner;
                end
            end
            SETUP: begin
                m_psel    = gpsel;
                cnt_nxt   = '0;
                state_nxt = gpsel ? ACCESS : IDLE;
            end
            ACCESS: begin
                m_psel    = gpsel;
                m_penable = gpsel;
                if (!gpsel || m_pready || timeout_hit) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        s0_pready  = done && !sel;
        s1_pready  = done && sel;
        s0_pslverr = err && !sel;
        s1_pslverr = err && sel;
        timeout_o  = timeout_hit;
    end

endmodule
